// File: rtl/tdc_pkg.sv
// tdc_pkg -- shared definitions for the TDC trace-capture block.
//   tdc_state_e   : capture FSM states (IDLE, ARMED, CAPTURE, DONE)
//   TDC_N_DEF     : default carry-chain length (thermometer width)
//   TDC_DEPTH_DEF : default trace buffer depth (power of two)
//   TDC_PIPE_LAT  : decode pipeline latency in clk cycles
//   TDC_GROUP     : bits per partial popcount group
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } tdc_state_e;

    localparam int TDC_N_DEF     = 128;
    localparam int TDC_DEPTH_DEF = 256;
    localparam int TDC_PIPE_LAT  = 3;
    localparam int TDC_GROUP     = 8;

endpackage

// File: rtl/tdc_trace_capture_if.sv
// tdc_trace_capture_if -- bus between the TDC capture block and its user.
//   master : drives therm, arm, trigger, rd_addr; observes decode, status,
//            trace read data and min/max.
//   slave  : the capture block itself.
interface tdc_trace_capture_if
    import tdc_pkg::*;
#(
    parameter int N     = TDC_N_DEF,
    parameter int DEPTH = TDC_DEPTH_DEF
) ();
    localparam int W  = $clog2(N + 1);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  therm;
    logic          arm;
    logic          trigger;
    logic [W-1:0]  code;
    logic          code_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  code_min;
    logic [W-1:0]  code_max;

    modport master (
        output therm, arm, trigger, rd_addr,
        input  code, code_valid, busy, done, rd_data, code_min, code_max
    );

    modport slave (
        input  therm, arm, trigger, rd_addr,
        output code, code_valid, busy, done, rd_data, code_min, code_max
    );
endinterface

// File: rtl/tdc_popcount.sv
// tdc_popcount -- two registered stages of a thermometer population count.
//   Stage 1: per-group counts of TDC_GROUP bits. Stage 2: sum of the groups.
//   Plain adders only, so bubbles in the thermometer code are counted
//   rather than truncating the result.
// Ports: clk, clr (sync, active high), din [N], count [W] (registered).
module tdc_popcount
    import tdc_pkg::*;
#(
    parameter int N = TDC_N_DEF,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] din,
    output logic [W-1:0] count
);
    localparam int GS = TDC_GROUP;
    localparam int NG = (N + GS - 1) / GS;
    localparam int NP = NG * GS;
    localparam int PW = $clog2(GS + 1);

    logic [NP-1:0]    din_pad_s;
    logic [NP-1:0]    din_tmp_s;
    logic [PW-1:0]    acc_s;
    logic [NG*PW-1:0] part_s;
    logic [NG*PW-1:0] part_r;
    logic [NG*PW-1:0] part_tmp_s;
    logic [W-1:0]     sum_s;
    logic [W-1:0]     count_r;

    if (NP == N) begin : g_nopad
        assign din_pad_s = din;
    end else begin : g_pad
        assign din_pad_s = {{(NP - N){1'b0}}, din};
    end

    // Per-group counts; group 0 ends up in the lowest slice of part_s.
    always_comb begin
        din_tmp_s = din_pad_s;
        part_s    = {(NG * PW){1'b0}};
        acc_s     = {PW{1'b0}};
        for (int g = 0; g < NG; g++) begin
            acc_s = {PW{1'b0}};
            for (int b = 0; b < GS; b++) begin
                acc_s     = acc_s + {{(PW - 1){1'b0}}, din_tmp_s[0]};
                din_tmp_s = din_tmp_s >> 1;
            end
            part_s = {acc_s, part_s[NG*PW-1:PW]};
        end
    end

    // Sum of all group counts, widened to W before adding.
    always_comb begin
        part_tmp_s = part_r;
        sum_s      = {W{1'b0}};
        for (int g = 0; g < NG; g++) begin
            sum_s      = sum_s + {{(W - PW){1'b0}}, part_tmp_s[PW-1:0]};
            part_tmp_s = part_tmp_s >> PW;
        end
    end

    // Pipeline registers for partial sums and final count.
    always_ff @(posedge clk) begin
        if (clr) begin
            part_r  <= {(NG * PW){1'b0}};
            count_r <= {W{1'b0}};
        end else begin
            part_r  <= part_s;
            count_r <= sum_s;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/tdc_trace_capture.sv
// tdc_trace_capture -- TDC thermometer decoder with triggered trace capture.
//   Decodes one thermometer sample per clk (3-cycle popcount pipeline) and,
//   once armed, stores DEPTH consecutive codes starting with the sample
//   taken in the trigger cycle.
// Ports: clk, clr (sync active-high reset), bus (tdc_trace_capture_if.slave:
//   therm, arm, trigger, rd_addr in; code, code_valid, busy, done, rd_data,
//   code_min, code_max out).
// Optional: define TDC_CAPTURE_MINMAX_EN to track min/max of each capture;
//   otherwise code_min/code_max are tied to 0.
module tdc_trace_capture
    import tdc_pkg::*;
#(
    parameter int N     = TDC_N_DEF,
    parameter int W     = $clog2(N + 1),
    parameter int DEPTH = TDC_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                clr,
    tdc_trace_capture_if.slave  bus
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    logic [N-1:0]            therm_r;
    logic [W-1:0]            code_s;
    logic [TDC_PIPE_LAT-1:0] valid_sr_r;
    logic [TDC_PIPE_LAT-1:0] trig_sr_r;
    tdc_state_e              state_r;
    logic [AW-1:0]           wr_ptr_r;
    logic                    busy_r;
    logic                    done_r;
    logic [W-1:0]            rd_data_r;
    logic [W-1:0]            mem_r [DEPTH];
    logic                    start_s;
    logic                    wr_en_s;

    // Input register: first decode stage.
    always_ff @(posedge clk) begin
        if (clr) begin
            therm_r <= {N{1'b0}};
        end else begin
            therm_r <= bus.therm;
        end
    end

    tdc_popcount #(.N(N), .W(W)) u_popcount (
        .clk   (clk),
        .clr   (clr),
        .din   (therm_r),
        .count (code_s)
    );

    // Valid and trigger delay lines matched to the decode latency. A trigger
    // only enters the line while ARMED, so a trigger seen in IDLE (even in
    // the arming cycle) or in DONE can never start a capture later.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_sr_r <= {TDC_PIPE_LAT{1'b0}};
            trig_sr_r  <= {TDC_PIPE_LAT{1'b0}};
        end else begin
            valid_sr_r <= {valid_sr_r[TDC_PIPE_LAT-2:0], 1'b1};
            trig_sr_r  <= {trig_sr_r[TDC_PIPE_LAT-2:0],
                           bus.trigger && (state_r == ST_ARMED)};
        end
    end

    // Capture start and buffer write enable; clr blocks the write at once.
    always_comb begin
        start_s = (state_r == ST_ARMED) && trig_sr_r[TDC_PIPE_LAT-1];
        if (clr) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = start_s || (state_r == ST_CAPTURE);
        end
    end

    // Capture FSM with registered busy/done. wr_ptr is 0 whenever ARMED, so
    // the first sample lands at address 0.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= {AW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.arm) begin
                        state_r  <= ST_ARMED;
                        wr_ptr_r <= {AW{1'b0}};
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (start_s) begin
                        state_r  <= ST_CAPTURE;
                        wr_ptr_r <= ADDR_ONE;
                    end
                end
                ST_CAPTURE: begin
                    if (wr_ptr_r == LAST_ADDR) begin
                        state_r  <= ST_DONE;
                        wr_ptr_r <= {AW{1'b0}};
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        wr_ptr_r <= wr_ptr_r + ADDR_ONE;
                    end
                end
                ST_DONE: begin
                    if (bus.arm) begin
                        state_r  <= ST_ARMED;
                        wr_ptr_r <= {AW{1'b0}};
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    wr_ptr_r <= {AW{1'b0}};
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    // Trace buffer write port; deliberately not reset so data survives clr.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= code_s;
        end
    end

    // Registered read port (read-before-write on an address collision).
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_data_r <= {W{1'b0}};
        end else begin
            rd_data_r <= mem_r[bus.rd_addr];
        end
    end

`ifdef TDC_CAPTURE_MINMAX_EN
    logic [W-1:0] min_r;
    logic [W-1:0] max_r;

    // Extremes of the current capture; held through DONE until next start.
    always_ff @(posedge clk) begin
        if (clr) begin
            min_r <= {W{1'b0}};
            max_r <= {W{1'b0}};
        end else if (start_s) begin
            min_r <= code_s;
            max_r <= code_s;
        end else if (state_r == ST_CAPTURE) begin
            if (code_s < min_r) begin
                min_r <= code_s;
            end
            if (code_s > max_r) begin
                max_r <= code_s;
            end
        end
    end

    assign bus.code_min = min_r;
    assign bus.code_max = max_r;
`else
    assign bus.code_min = {W{1'b0}};
    assign bus.code_max = {W{1'b0}};
`endif

    assign bus.code       = code_s;
    assign bus.code_valid = valid_sr_r[TDC_PIPE_LAT-1];
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.rd_data    = rd_data_r;
endmodule
